// File: rtl/axil_arbiter_pkg.sv
// Shared types and constants for the two-master AXI-lite arbiter.
package axil_arbiter_pkg;

  typedef enum logic [2:0] {StIdle, StAr, StR, StWr, StB} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIfu, OwnLsu} owner_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic owner_e other_master(owner_e m);
    return (m == OwnIfu) ? OwnLsu : OwnIfu;
  endfunction

endpackage

// File: rtl/axil_arbiter.sv
// Merges the IFU read port and LSU read/write port onto one AXI-lite master port.
// One transaction outstanding; ownership is held from grant until the response handshake.
module axil_arbiter
  import axil_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  output logic                out_arvalid,
  input  logic                out_arready,
  output logic [ADDR_W-1:0]   out_araddr,
  input  logic                out_rvalid,
  output logic                out_rready,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic [1:0]          out_rresp,
  output logic                out_awvalid,
  input  logic                out_awready,
  output logic [ADDR_W-1:0]   out_awaddr,
  output logic                out_wvalid,
  input  logic                out_wready,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  input  logic                out_bvalid,
  output logic                out_bready,
  input  logic [1:0]          out_bresp
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e rr_q, rr_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnNone;
      rr_q      <= OwnLsu;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    out_arvalid = 1'b0;
    out_rready  = 1'b0;
    out_awvalid = 1'b0;
    out_wvalid  = 1'b0;
    out_bready  = 1'b0;
    // Payloads are forwarded unconditionally; only the valids/readies are steered.
    out_araddr  = (owner_q == OwnIfu) ? ifu_araddr : lsu_araddr;
    out_awaddr  = lsu_awaddr;
    out_wdata   = lsu_wdata;
    out_wstrb   = lsu_wstrb;
    ifu_rdata   = out_rdata;
    ifu_rresp   = out_rresp;
    lsu_rdata   = out_rdata;
    lsu_rresp   = out_rresp;
    lsu_bresp   = out_bresp;

    unique case (state_q)
      StIdle: begin
        if (lsu_awvalid) begin
          owner_d = OwnLsu;
          state_d = StWr;
        end else if (ifu_arvalid && lsu_arvalid) begin
          owner_d = rr_q;
          rr_d    = other_master(rr_q);
          state_d = StAr;
        end else if (ifu_arvalid) begin
          owner_d = OwnIfu;
          rr_d    = OwnLsu;
          state_d = StAr;
        end else if (lsu_arvalid) begin
          owner_d = OwnLsu;
          rr_d    = OwnIfu;
          state_d = StAr;
        end
      end
      StAr: begin
        if (owner_q == OwnIfu) begin
          out_arvalid = ifu_arvalid;
          ifu_arready = out_arready;
        end else begin
          out_arvalid = lsu_arvalid;
          lsu_arready = out_arready;
        end
        if (out_arvalid && out_arready) state_d = StR;
      end
      StR: begin
        if (owner_q == OwnIfu) begin
          ifu_rvalid = out_rvalid;
          out_rready = ifu_rready;
        end else begin
          lsu_rvalid = out_rvalid;
          out_rready = lsu_rready;
        end
        if (out_rvalid && out_rready) begin
          owner_d = OwnNone;
          state_d = StIdle;
        end
      end
      StWr: begin
        out_awvalid = lsu_awvalid && !aw_done_q;
        lsu_awready = out_awready && !aw_done_q;
        out_wvalid  = lsu_wvalid && !w_done_q;
        lsu_wready  = out_wready && !w_done_q;
        aw_done_d   = aw_done_q || (out_awvalid && out_awready);
        w_done_d    = w_done_q || (out_wvalid && out_wready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StB;
        end
      end
      StB: begin
        lsu_bvalid = out_bvalid;
        out_bready = lsu_bready;
        if (out_bvalid && out_bready) begin
          owner_d = OwnNone;
          state_d = StIdle;
        end
      end
      default: begin
        owner_d = OwnNone;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_arbiter.sv
// Directed and randomized checks of axil_arbiter against a transaction-order model.
module tb_axil_arbiter;
  import axil_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_bvalid, lsu_bready;
  logic [1:0]  lsu_bresp;
  logic        out_arvalid, out_arready, out_rvalid, out_rready;
  logic [31:0] out_araddr, out_rdata;
  logic [1:0]  out_rresp;
  logic        out_awvalid, out_awready, out_wvalid, out_wready;
  logic [31:0] out_awaddr, out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_bvalid, out_bready;
  logic [1:0]  out_bresp;

  always #5 clk = ~clk;

  wire [11:0] vr_outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready,
                         lsu_wready, lsu_bvalid, out_arvalid, out_rready, out_awvalid,
                         out_wvalid, out_bready};

  axil_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr),
    .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata),
    .out_rresp(out_rresp),
    .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr),
    .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata),
    .out_wstrb(out_wstrb),
    .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp)
  );

  // kind: 0 = IFU read, 1 = LSU read, 2 = LSU write
  typedef struct {
    int          kind;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pref;  // master that wins a simultaneous read request: 0 = IFU, 1 = LSU

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = '0; lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_bready = 0;
    out_arready = 0; out_rvalid = 0; out_rdata = '0; out_rresp = '0;
    out_awready = 0; out_wready = 0; out_bvalid = 0; out_bresp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    pref = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Raises the requested transactions together, plays a randomly-timed crossbar and checks
  // every grant and response against the order derived from the arbitration rules.
  task automatic run_round(input logic do_ifu, input logic do_lrd, input logic do_wr,
                           input logic [31:0] a_ifu, input logic [31:0] a_lrd,
                           input logic [31:0] a_wr, input logic [31:0] wd,
                           input logic [3:0] ws);
    exp_t        e;
    logic        r_ifu, r_lsu, ifu_pend, lrd_pend, aw_pend, w_pend;
    logic        rd_busy, b_busy, aw_seen, w_seen;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int          rd_cnt, b_cnt, pick, cycles, k;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp, b_resp;

    exp_q.delete();
    if (do_wr) begin
      e.kind = 2; e.addr = a_wr; exp_q.push_back(e);
    end
    r_ifu = do_ifu;
    r_lsu = do_lrd;
    while (r_ifu || r_lsu) begin
      pick = (r_ifu && r_lsu) ? pref : (r_ifu ? 0 : 1);
      e.kind = pick;
      e.addr = (pick == 0) ? a_ifu : a_lrd;
      exp_q.push_back(e);
      pref = 1 - pick;
      if (pick == 0) r_ifu = 0; else r_lsu = 0;
    end

    ifu_pend = do_ifu; lrd_pend = do_lrd; aw_pend = do_wr; w_pend = do_wr;
    rd_busy = 0; b_busy = 0; aw_seen = 0; w_seen = 0;
    rd_cnt = 0; b_cnt = 0; rd_data = '0; rd_resp = '0; b_resp = '0;
    ifu_araddr = a_ifu; lsu_araddr = a_lrd; lsu_awaddr = a_wr; lsu_wdata = wd;
    lsu_wstrb = ws;

    for (cycles = 0; exp_q.size() != 0 && cycles < 300; cycles++) begin
      ifu_arvalid = ifu_pend; lsu_arvalid = lrd_pend;
      lsu_awvalid = aw_pend;  lsu_wvalid  = w_pend;
      out_arready = 1'($urandom_range(0, 1));
      out_awready = 1'($urandom_range(0, 1));
      out_wready  = 1'($urandom_range(0, 1));
      out_rvalid  = rd_busy && (rd_cnt == 0);
      out_rdata   = rd_data; out_rresp = rd_resp;
      out_bvalid  = b_busy && (b_cnt == 0);
      out_bresp   = b_resp;
      ifu_rready  = ($urandom_range(0, 3) != 0);
      lsu_rready  = ($urandom_range(0, 3) != 0);
      lsu_bready  = ($urandom_range(0, 3) != 0);
      #1;
      ar_hs = out_arvalid && out_arready;
      r_hs  = out_rvalid && out_rready;
      aw_hs = out_awvalid && out_awready;
      w_hs  = out_wvalid && out_wready;
      b_hs  = out_bvalid && out_bready;
      chk("rvalid_exclusive", ifu_rvalid & lsu_rvalid, 0);
      if (exp_q.size() != 0 && exp_q[0].kind == 2) chk("ar_blocked_by_write", out_arvalid, 0);
      if (rd_busy && rd_cnt > 0) rd_cnt--;
      if (b_busy && b_cnt > 0) b_cnt--;

      if (ar_hs) begin
        if (exp_q.size() == 0 || exp_q[0].kind == 2) chk("ar_unexpected", out_arvalid, 0);
        else begin
          chk("ar_addr", out_araddr, exp_q[0].addr);
          chk("ar_to_ifu", ifu_arready, exp_q[0].kind == 0);
          chk("ar_to_lsu", lsu_arready, exp_q[0].kind == 1);
        end
        if (ifu_arvalid && ifu_arready) ifu_pend = 0;
        if (lsu_arvalid && lsu_arready) lrd_pend = 0;
        rd_busy = 1;
        rd_cnt  = $urandom_range(0, 3);
        rd_data = $urandom;
        rd_resp = 2'($urandom_range(0, 3));
      end
      if (r_hs) begin
        if (exp_q.size() == 0) chk("r_unexpected", out_rready, 0);
        else begin
          k = exp_q[0].kind;
          chk("r_ifu_rvalid", ifu_rvalid, k == 0);
          chk("r_lsu_rvalid", lsu_rvalid, k == 1);
          chk("r_data", (k == 0) ? ifu_rdata : lsu_rdata, out_rdata);
          chk("r_resp", (k == 0) ? ifu_rresp : lsu_rresp, out_rresp);
          void'(exp_q.pop_front());
        end
        rd_busy = 0;
      end
      if (aw_hs) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 2) chk("aw_unexpected", out_awvalid, 0);
        else begin
          chk("aw_addr", out_awaddr, exp_q[0].addr);
          chk("aw_ready", lsu_awready, 1);
        end
        if (lsu_awvalid && lsu_awready) aw_pend = 0;
        aw_seen = 1;
      end
      if (w_hs) begin
        chk("w_data", out_wdata, wd);
        chk("w_strb", out_wstrb, ws);
        chk("w_ready", lsu_wready, 1);
        if (lsu_wvalid && lsu_wready) w_pend = 0;
        w_seen = 1;
      end
      if (aw_seen && w_seen && !b_busy) begin
        b_busy = 1; b_cnt = $urandom_range(0, 3); b_resp = 2'($urandom_range(0, 3));
        aw_seen = 0; w_seen = 0;
      end
      if (b_hs) begin
        chk("b_valid", lsu_bvalid, 1);
        chk("b_resp", lsu_bresp, out_bresp);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        b_busy = 0;
      end
      cyc();
    end
    chk("round_complete", exp_q.size(), 0);
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       di, dl, dw;
    logic [31:0] a0, a1, a2;

    rst = 1'b1;
    clear_inputs();
    #1;
    ifu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1; out_arready = 1; out_rvalid = 1;
    out_bvalid = 1; ifu_rready = 1; lsu_bready = 1; out_awready = 1; out_wready = 1;
    #1;
    chk("reset_outs", vr_outs, 0);
    do_reset();
    #1;
    chk("post_reset_idle", vr_outs, 0);

    // IFU read with a two-cycle crossbar response.
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; out_arready = 1;
    #1;
    chk("a_idle_arvalid", out_arvalid, 0);
    chk("a_idle_arready", ifu_arready, 0);
    cyc();
    chk("a_ar_valid", out_arvalid, 1);
    chk("a_ar_addr", out_araddr, 32'h8000_0000);
    chk("a_ar_ready", ifu_arready, 1);
    chk("a_lsu_arready", lsu_arready, 0);
    cyc();
    ifu_arvalid = 0; out_arready = 0; ifu_rready = 1;
    #1;
    chk("a_r_wait", ifu_rvalid, 0);
    cyc();
    out_rvalid = 1; out_rdata = 32'hDEAD_BEEF; out_rresp = RESP_OKAY;
    #1;
    chk("a_r_valid", ifu_rvalid, 1);
    chk("a_r_data", ifu_rdata, 32'hDEAD_BEEF);
    chk("a_r_resp", ifu_rresp, RESP_OKAY);
    chk("a_lsu_rvalid", lsu_rvalid, 0);
    chk("a_r_ready", out_rready, 1);
    cyc();
    out_rvalid = 0; ifu_rready = 0;
    #1;
    chk("a_idle_after", vr_outs, 0);

    // LSU read answered with DECERR while the LSU stalls rready for five cycles.
    lsu_arvalid = 1; lsu_araddr = 32'h0000_0000; out_arready = 1;
    cyc();
    chk("h_ar_addr", out_araddr, 32'h0000_0000);
    chk("h_lsu_arready", lsu_arready, 1);
    chk("h_ifu_arready", ifu_arready, 0);
    cyc();
    lsu_arvalid = 0; out_arready = 0; out_rvalid = 1; out_rdata = 32'h1234_5678;
    out_rresp = RESP_DECERR; lsu_rready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("h_rready_low", out_rready, 0);
      chk("h_rvalid_held", lsu_rvalid, 1);
      cyc();
    end
    lsu_rready = 1;
    #1;
    chk("h_rready_high", out_rready, 1);
    chk("h_rresp_decerr", lsu_rresp, RESP_DECERR);
    chk("h_rdata", lsu_rdata, 32'h1234_5678);
    chk("h_ifu_rvalid", ifu_rvalid, 0);
    cyc();
    chk("h_single_hs_rvalid", lsu_rvalid, 0);
    chk("h_single_hs_rready", out_rready, 0);
    clear_inputs();

    // LSU write beats a pending IFU read; W lands two cycles before AW.
    lsu_awvalid = 1; lsu_awaddr = 32'h1000_0000; lsu_wvalid = 1; lsu_wdata = 32'h41;
    lsu_wstrb = 4'b0001; ifu_arvalid = 1; ifu_araddr = 32'h8000_0030;
    out_wready = 1; out_awready = 0; lsu_bready = 1;
    #1;
    chk("w_idle_wready", lsu_wready, 0);
    cyc();
    chk("w_awvalid", out_awvalid, 1);
    chk("w_wvalid", out_wvalid, 1);
    chk("w_wready", lsu_wready, 1);
    chk("w_wdata", out_wdata, 32'h41);
    chk("w_wstrb", out_wstrb, 4'b0001);
    chk("w_ar_blocked", out_arvalid, 0);
    chk("w_ifu_arready", ifu_arready, 0);
    cyc();
    lsu_wvalid = 0; out_wready = 0;
    #1;
    chk("w_wdone", out_wvalid, 0);
    chk("w_aw_pending", out_awvalid, 1);
    chk("w_awready_gated", lsu_awready, 0);
    cyc();
    out_awready = 1;
    #1;
    chk("w_aw_addr", out_awaddr, 32'h1000_0000);
    chk("w_awready", lsu_awready, 1);
    chk("w_no_b_yet", lsu_bvalid, 0);
    cyc();
    lsu_awvalid = 0; out_awready = 0; out_bvalid = 1; out_bresp = RESP_OKAY;
    #1;
    chk("w_bvalid", lsu_bvalid, 1);
    chk("w_bready", out_bready, 1);
    chk("w_bresp", lsu_bresp, RESP_OKAY);
    chk("w_ar_still_blocked", out_arvalid, 0);
    cyc();
    chk("w_b_single", lsu_bvalid, 0);
    chk("w_bready_after", out_bready, 0);
    chk("w_idle_bubble", out_arvalid, 0);
    out_bvalid = 0;
    cyc();
    out_arready = 1;
    #1;
    chk("w_then_ar", out_arvalid, 1);
    chk("w_then_ar_addr", out_araddr, 32'h8000_0030);
    chk("w_then_ifu_arready", ifu_arready, 1);
    cyc();
    ifu_arvalid = 0; out_arready = 0; out_rvalid = 1; out_rdata = 32'hCAFE_0030;
    ifu_rready = 1;
    #1;
    chk("w_then_rvalid", ifu_rvalid, 1);
    chk("w_then_rdata", ifu_rdata, 32'hCAFE_0030);
    cyc();
    clear_inputs();
    #1;
    chk("w_idle_after", vr_outs, 0);
    cyc();

    // Simultaneous reads straight after reset: LSU first, then IFU.
    do_reset();
    run_round(1, 1, 0, 32'h8000_0010, 32'h8000_0020, 32'h0, 32'h0, 4'h0);

    // Asynchronous reset during R.
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0040; out_arready = 1;
    cyc();
    cyc();
    ifu_arvalid = 0; out_rvalid = 1; out_rdata = 32'h5555_0040; ifu_rready = 0;
    #1;
    chk("ar_rst_in_r", ifu_rvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rst_outs", vr_outs, 0);
    pref = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    run_round(1, 0, 0, 32'h8000_0044, 32'h0, 32'h0, 32'h0, 4'h0);

    // Randomized mixes of reads and writes.
    for (int r = 0; r < 40; r++) begin
      di = 1'($urandom_range(0, 1));
      dl = 1'($urandom_range(0, 1));
      dw = ($urandom_range(0, 2) == 0);
      if (!(di || dl || dw)) di = 1;
      a0 = $urandom & 32'hFFFF_FFFC;
      a1 = $urandom & 32'hFFFF_FFFC;
      a2 = $urandom & 32'hFFFF_FFFC;
      run_round(di, dl, dw, a0, a1, a2, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
